// File: rtl/alu_decode_stage.sv
// ID/EX boundary: decodes a MIPS ALU instruction into aluop/operands and holds
// the result in a single valid/ready register that feeds the execute stage.
module alu_decode_stage (
   input  logic        clk,
   input  logic        rst,
   input  logic        id_valid,
   output logic        id_ready,
   input  logic [31:0] id_instr,
   output logic [4:0]  rf_raddr1,
   output logic [4:0]  rf_raddr2,
   input  logic [31:0] rf_rdata1,
   input  logic [31:0] rf_rdata2,
   input  logic        flush,
   output logic        ex_valid,
   input  logic        ex_ready,
   output logic [4:0]  ex_aluop,
   output logic [31:0] ex_a,
   output logic [31:0] ex_b,
   output logic [4:0]  ex_wreg,
   output logic        ex_wen,
   output logic        ex_trap_ovf,
   output logic        ex_illegal
);

   localparam logic [4:0] ALU_NOP   = 5'd0;
   localparam logic [4:0] ALU_ADD   = 5'd1;
   localparam logic [4:0] ALU_SUB   = 5'd2;
   localparam logic [4:0] ALU_AND   = 5'd3;
   localparam logic [4:0] ALU_OR    = 5'd4;
   localparam logic [4:0] ALU_SLT   = 5'd5;
   localparam logic [4:0] ALU_SLTU  = 5'd6;
   localparam logic [4:0] ALU_NOR   = 5'd7;
   localparam logic [4:0] ALU_XOR   = 5'd8;
   localparam logic [4:0] ALU_SLL   = 5'd9;
   localparam logic [4:0] ALU_SRL   = 5'd10;
   localparam logic [4:0] ALU_SRA   = 5'd11;
   localparam logic [4:0] ALU_SLLV  = 5'd12;
   localparam logic [4:0] ALU_SRLV  = 5'd13;
   localparam logic [4:0] ALU_SRAV  = 5'd14;
   localparam logic [4:0] ALU_SLL16 = 5'd15;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ADDIU = 6'h09;
   localparam logic [5:0] OP_SLTI  = 6'h0A;
   localparam logic [5:0] OP_SLTIU = 6'h0B;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_XORI  = 6'h0E;
   localparam logic [5:0] OP_LUI   = 6'h0F;

   localparam logic [5:0] FN_SLL  = 6'h00;
   localparam logic [5:0] FN_SRL  = 6'h02;
   localparam logic [5:0] FN_SRA  = 6'h03;
   localparam logic [5:0] FN_SLLV = 6'h04;
   localparam logic [5:0] FN_SRLV = 6'h06;
   localparam logic [5:0] FN_SRAV = 6'h07;
   localparam logic [5:0] FN_ADD  = 6'h20;
   localparam logic [5:0] FN_ADDU = 6'h21;
   localparam logic [5:0] FN_SUB  = 6'h22;
   localparam logic [5:0] FN_SUBU = 6'h23;
   localparam logic [5:0] FN_AND  = 6'h24;
   localparam logic [5:0] FN_OR   = 6'h25;
   localparam logic [5:0] FN_XOR  = 6'h26;
   localparam logic [5:0] FN_NOR  = 6'h27;
   localparam logic [5:0] FN_SLT  = 6'h2A;
   localparam logic [5:0] FN_SLTU = 6'h2B;

   logic [5:0]  op;
   logic [5:0]  funct;
   logic [4:0]  rs;
   logic [4:0]  rt;
   logic [4:0]  rd;
   logic [4:0]  shamt;
   logic [15:0] imm;
   logic [31:0] imm_sext;
   logic [31:0] imm_zext;

   assign op       = id_instr[31:26];
   assign rs       = id_instr[25:21];
   assign rt       = id_instr[20:16];
   assign rd       = id_instr[15:11];
   assign shamt    = id_instr[10:6];
   assign funct    = id_instr[5:0];
   assign imm      = id_instr[15:0];
   assign imm_sext = {{16{imm[15]}}, imm};
   assign imm_zext = {16'h0000, imm};

   assign rf_raddr1 = rs;
   assign rf_raddr2 = rt;

   logic        dec_legal;
   logic [4:0]  dec_aluop;
   logic [31:0] dec_a;
   logic [31:0] dec_b;
   logic [4:0]  dec_dest;
   logic        dec_trap;

   // Raw decode; illegal words are normalised afterwards in one place.
   always_comb begin
      dec_legal = 1'b1;
      dec_aluop = ALU_NOP;
      dec_a     = rf_rdata1;
      dec_b     = rf_rdata2;
      dec_dest  = rt;
      dec_trap  = 1'b0;
      case (op)
         OP_RTYPE: begin
            dec_dest = rd;
            case (funct)
               FN_SLL: begin
                  dec_aluop = ALU_SLL;
                  dec_a     = {27'b0, shamt};
               end
               FN_SRL: begin
                  dec_aluop = ALU_SRL;
                  dec_a     = {27'b0, shamt};
               end
               FN_SRA: begin
                  dec_aluop = ALU_SRA;
                  dec_a     = {27'b0, shamt};
               end
               FN_SLLV: dec_aluop = ALU_SLLV;
               FN_SRLV: dec_aluop = ALU_SRLV;
               FN_SRAV: dec_aluop = ALU_SRAV;
               FN_ADD: begin
                  dec_aluop = ALU_ADD;
                  dec_trap  = 1'b1;
               end
               FN_ADDU: dec_aluop = ALU_ADD;
               FN_SUB: begin
                  dec_aluop = ALU_SUB;
                  dec_trap  = 1'b1;
               end
               FN_SUBU: dec_aluop = ALU_SUB;
               FN_AND:  dec_aluop = ALU_AND;
               FN_OR:   dec_aluop = ALU_OR;
               FN_XOR:  dec_aluop = ALU_XOR;
               FN_NOR:  dec_aluop = ALU_NOR;
               FN_SLT:  dec_aluop = ALU_SLT;
               FN_SLTU: dec_aluop = ALU_SLTU;
               default: dec_legal = 1'b0;
            endcase
         end
         OP_ADDI: begin
            dec_aluop = ALU_ADD;
            dec_b     = imm_sext;
            dec_trap  = 1'b1;
         end
         OP_ADDIU: begin
            dec_aluop = ALU_ADD;
            dec_b     = imm_sext;
         end
         OP_SLTI: begin
            dec_aluop = ALU_SLT;
            dec_b     = imm_sext;
         end
         OP_SLTIU: begin
            dec_aluop = ALU_SLTU;
            dec_b     = imm_sext;
         end
         OP_ANDI: begin
            dec_aluop = ALU_AND;
            dec_b     = imm_zext;
         end
         OP_ORI: begin
            dec_aluop = ALU_OR;
            dec_b     = imm_zext;
         end
         OP_XORI: begin
            dec_aluop = ALU_XOR;
            dec_b     = imm_zext;
         end
         OP_LUI: begin
            dec_aluop = ALU_SLL16;
            dec_a     = 32'h0000_0000;
            dec_b     = imm_zext;
         end
         default: dec_legal = 1'b0;
      endcase
   end

   logic [4:0]  nxt_aluop;
   logic [31:0] nxt_a;
   logic [31:0] nxt_b;
   logic [4:0]  nxt_wreg;
   logic        nxt_wen;
   logic        nxt_trap;
   logic        nxt_illegal;

   // Illegal words travel as a harmless NOP slot carrying rs for diagnostics.
   always_comb begin
      nxt_illegal = !dec_legal;
      if (dec_legal) begin
         nxt_aluop = dec_aluop;
         nxt_a     = dec_a;
         nxt_b     = dec_b;
         nxt_wreg  = dec_dest;
         nxt_wen   = (dec_dest != 5'd0);
         nxt_trap  = dec_trap;
      end else begin
         nxt_aluop = ALU_NOP;
         nxt_a     = rf_rdata1;
         nxt_b     = 32'h0000_0000;
         nxt_wreg  = 5'd0;
         nxt_wen   = 1'b0;
         nxt_trap  = 1'b0;
      end
   end

   logic take;

   assign id_ready = !ex_valid || ex_ready;
   assign take     = id_valid && id_ready && !flush;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ex_valid    <= 1'b0;
         ex_aluop    <= ALU_NOP;
         ex_a        <= 32'h0000_0000;
         ex_b        <= 32'h0000_0000;
         ex_wreg     <= 5'd0;
         ex_wen      <= 1'b0;
         ex_trap_ovf <= 1'b0;
         ex_illegal  <= 1'b0;
      end else if (flush) begin
         ex_valid <= 1'b0;
         ex_wen   <= 1'b0;
      end else if (take) begin
         ex_valid    <= 1'b1;
         ex_aluop    <= nxt_aluop;
         ex_a        <= nxt_a;
         ex_b        <= nxt_b;
         ex_wreg     <= nxt_wreg;
         ex_wen      <= nxt_wen;
         ex_trap_ovf <= nxt_trap;
         ex_illegal  <= nxt_illegal;
      end else if (ex_ready) begin
         ex_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_alu_decode_stage.sv
// Directed-vector bench for alu_decode_stage: decode table, back-pressure,
// flush and asynchronous reset behaviour.
module tb_alu_decode_stage;

   logic        clk;
   logic        rst;
   logic        id_valid;
   logic        id_ready;
   logic [31:0] id_instr;
   logic [4:0]  rf_raddr1;
   logic [4:0]  rf_raddr2;
   logic [31:0] rf_rdata1;
   logic [31:0] rf_rdata2;
   logic        flush;
   logic        ex_valid;
   logic        ex_ready;
   logic [4:0]  ex_aluop;
   logic [31:0] ex_a;
   logic [31:0] ex_b;
   logic [4:0]  ex_wreg;
   logic        ex_wen;
   logic        ex_trap_ovf;
   logic        ex_illegal;

   int n_vec;
   int n_err;

   alu_decode_stage dut (
      .clk         (clk),
      .rst         (rst),
      .id_valid    (id_valid),
      .id_ready    (id_ready),
      .id_instr    (id_instr),
      .rf_raddr1   (rf_raddr1),
      .rf_raddr2   (rf_raddr2),
      .rf_rdata1   (rf_rdata1),
      .rf_rdata2   (rf_rdata2),
      .flush       (flush),
      .ex_valid    (ex_valid),
      .ex_ready    (ex_ready),
      .ex_aluop    (ex_aluop),
      .ex_a        (ex_a),
      .ex_b        (ex_b),
      .ex_wreg     (ex_wreg),
      .ex_wen      (ex_wen),
      .ex_trap_ovf (ex_trap_ovf),
      .ex_illegal  (ex_illegal)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, want %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Drive one word with ex_ready=1, check read addresses, then the captured slot.
   task automatic run_vec(input string tag, input logic [31:0] instr,
                          input logic [31:0] rd1, input logic [31:0] rd2,
                          input logic [4:0] e_op, input logic [31:0] e_a,
                          input logic [31:0] e_b, input logic [4:0] e_wreg,
                          input logic e_wen, input logic e_trap, input logic e_ill);
      logic [31:0] w;
      w         = instr;
      id_instr  = instr;
      rf_rdata1 = rd1;
      rf_rdata2 = rd2;
      id_valid  = 1'b1;
      ex_ready  = 1'b1;
      #1;
      chk({tag, ".raddr1"}, {27'b0, rf_raddr1}, {27'b0, w[25:21]});
      chk({tag, ".raddr2"}, {27'b0, rf_raddr2}, {27'b0, w[20:16]});
      step();
      chk({tag, ".valid"}, {31'b0, ex_valid}, 32'd1);
      chk({tag, ".aluop"}, {27'b0, ex_aluop}, {27'b0, e_op});
      chk({tag, ".a"}, ex_a, e_a);
      chk({tag, ".b"}, ex_b, e_b);
      if (!e_ill) chk({tag, ".wreg"}, {27'b0, ex_wreg}, {27'b0, e_wreg});
      chk({tag, ".wen"}, {31'b0, ex_wen}, {31'b0, e_wen});
      chk({tag, ".trap"}, {31'b0, ex_trap_ovf}, {31'b0, e_trap});
      chk({tag, ".illegal"}, {31'b0, ex_illegal}, {31'b0, e_ill});
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, ".valid"}, {31'b0, ex_valid}, 32'd0);
      chk({tag, ".aluop"}, {27'b0, ex_aluop}, 32'd0);
      chk({tag, ".a"}, ex_a, 32'd0);
      chk({tag, ".b"}, ex_b, 32'd0);
      chk({tag, ".wreg"}, {27'b0, ex_wreg}, 32'd0);
      chk({tag, ".wen"}, {31'b0, ex_wen}, 32'd0);
      chk({tag, ".trap"}, {31'b0, ex_trap_ovf}, 32'd0);
      chk({tag, ".illegal"}, {31'b0, ex_illegal}, 32'd0);
   endtask

   logic [31:0] bp_k [4];

   initial begin
      n_vec     = 0;
      n_err     = 0;
      rst       = 1'b1;
      id_valid  = 1'b0;
      id_instr  = 32'h0;
      rf_rdata1 = 32'h0;
      rf_rdata2 = 32'h0;
      flush     = 1'b0;
      ex_ready  = 1'b0;
      repeat (2) step();
      chk_all_zero("reset");
      chk("reset.id_ready", {31'b0, id_ready}, 32'd1);
      rst = 1'b0;
      step();

      //       tag      instr         rs data       rt data       op     a             b             wreg   wen   trap  ill
      run_vec("addiu", 32'h2509FFFF, 32'h00000010, 32'h0,        5'd1,  32'h00000010, 32'hFFFFFFFF, 5'd9,  1'b1, 1'b0, 1'b0);
      run_vec("sll",   32'h00095100, 32'h12345678, 32'hA5A5A5A5, 5'd9,  32'h00000004, 32'hA5A5A5A5, 5'd10, 1'b1, 1'b0, 1'b0);
      run_vec("lui",   32'h3C0B1234, 32'hDEADBEEF, 32'h0,        5'd15, 32'h00000000, 32'h00001234, 5'd11, 1'b1, 1'b0, 1'b0);
      run_vec("add",   32'h01095020, 32'h00000003, 32'h00000005, 5'd1,  32'h00000003, 32'h00000005, 5'd10, 1'b1, 1'b1, 1'b0);
      run_vec("ill23", 32'h8D090000, 32'h00000077, 32'h00000099, 5'd0,  32'h00000077, 32'h00000000, 5'd0,  1'b0, 1'b0, 1'b1);
      run_vec("nop",   32'h00000000, 32'h0,        32'h0,        5'd9,  32'h00000000, 32'h00000000, 5'd0,  1'b0, 1'b0, 1'b0);
      run_vec("subu",  32'h01095023, 32'h00000010, 32'h00000001, 5'd2,  32'h00000010, 32'h00000001, 5'd10, 1'b1, 1'b0, 1'b0);
      run_vec("andi",  32'h3109F0F0, 32'hFFFFFFFF, 32'h0,        5'd3,  32'hFFFFFFFF, 32'h0000F0F0, 5'd9,  1'b1, 1'b0, 1'b0);
      run_vec("slti",  32'h2909FFFE, 32'h00000001, 32'h0,        5'd5,  32'h00000001, 32'hFFFFFFFE, 5'd9,  1'b1, 1'b0, 1'b0);
      run_vec("fn28",  32'h01095028, 32'h00000042, 32'h00000043, 5'd0,  32'h00000042, 32'h00000000, 5'd0,  1'b0, 1'b0, 1'b1);
      run_vec("sltu",  32'h0109502B, 32'h00000002, 32'h00000003, 5'd6,  32'h00000002, 32'h00000003, 5'd10, 1'b1, 1'b0, 1'b0);
      run_vec("srav",  32'h01095007, 32'h00000008, 32'h80000000, 5'd14, 32'h00000008, 32'h80000000, 5'd10, 1'b1, 1'b0, 1'b0);
      run_vec("xori",  32'h3909FFFF, 32'h0000AAAA, 32'h0,        5'd8,  32'h0000AAAA, 32'h0000FFFF, 5'd9,  1'b1, 1'b0, 1'b0);
      run_vec("addi",  32'h2109FFFF, 32'h00000001, 32'h0,        5'd1,  32'h00000001, 32'hFFFFFFFF, 5'd9,  1'b1, 1'b1, 1'b0);
      run_vec("addi0", 32'h21000005, 32'h00000001, 32'h0,        5'd1,  32'h00000001, 32'h00000005, 5'd0,  1'b0, 1'b1, 1'b0);
      run_vec("nor",   32'h01095027, 32'h0F0F0F0F, 32'h00FF00FF, 5'd7,  32'h0F0F0F0F, 32'h00FF00FF, 5'd10, 1'b1, 1'b0, 1'b0);

      // Back-pressure: NOR slot is held while W0 waits at the input.
      bp_k[0] = 32'h11;
      bp_k[1] = 32'h22;
      bp_k[2] = 32'h33;
      bp_k[3] = 32'h44;
      rf_rdata1 = 32'h0;
      rf_rdata2 = 32'h0;
      ex_ready  = 1'b0;
      id_valid  = 1'b1;
      id_instr  = 32'h24090000 | bp_k[0];
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("stall.id_ready", {31'b0, id_ready}, 32'd0);
         step();
         chk("stall.valid", {31'b0, ex_valid}, 32'd1);
         chk("stall.aluop", {27'b0, ex_aluop}, 32'd7);
         chk("stall.a", ex_a, 32'h0F0F0F0F);
         chk("stall.b", ex_b, 32'h00FF00FF);
      end
      ex_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         id_instr = 32'h24090000 | bp_k[i];
         step();
         chk("drain.valid", {31'b0, ex_valid}, 32'd1);
         chk("drain.b", ex_b, bp_k[i]);
      end

      // Flush while stalled: held 0x44 slot is dropped and 0x55 never captured.
      ex_ready = 1'b0;
      id_instr = 32'h24090055;
      step();
      chk("fl_stall.b", ex_b, 32'h44);
      flush = 1'b1;
      step();
      chk("flush.valid", {31'b0, ex_valid}, 32'd0);
      chk("flush.wen", {31'b0, ex_wen}, 32'd0);
      flush    = 1'b0;
      id_valid = 1'b0;
      ex_ready = 1'b1;
      repeat (2) begin
         step();
         chk("post_flush.valid", {31'b0, ex_valid}, 32'd0);
      end

      // Flush with an incoming word: accepted by ready but not captured.
      id_valid = 1'b1;
      id_instr = 32'h24090066;
      flush    = 1'b1;
      #1;
      chk("flush_in.id_ready", {31'b0, id_ready}, 32'd1);
      step();
      chk("flush_in.valid", {31'b0, ex_valid}, 32'd0);
      flush = 1'b0;
      step();
      chk("after_flush.valid", {31'b0, ex_valid}, 32'd1);
      chk("after_flush.b", ex_b, 32'h66);

      // Asynchronous reset mid-stream, checked before the next edge.
      id_instr  = 32'h01095020;
      rf_rdata1 = 32'h5;
      rf_rdata2 = 32'h6;
      step();
      chk("pre_rst.trap", {31'b0, ex_trap_ovf}, 32'd1);
      #2;
      rst = 1'b1;
      #1;
      chk_all_zero("async_rst");
      #1;
      rst      = 1'b0;
      id_valid = 1'b0;
      step();
      chk("rst_idle.valid", {31'b0, ex_valid}, 32'd0);
      id_valid = 1'b1;
      step();
      chk("rst_first.valid", {31'b0, ex_valid}, 32'd1);
      chk("rst_first.a", ex_a, 32'h5);
      chk("rst_first.b", ex_b, 32'h6);
      id_valid = 1'b0;
      step();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/alu_decode_stage.md
# alu_decode_stage

Decode-side producer for the ALU: accepts a fetched MIPS instruction word plus register-file read data, decodes opcode/funct into the 5-bit `aluop` code and the ALU operands `a`/`b`, and holds them in a single valid/ready pipeline register feeding the execute stage. It is the ID/EX boundary of the core. It also flags overflow-trapping and unsupported instructions, and supports stall (back-pressure) and flush.

## Interface

Parameters: none. aluop encoding is from `define.v` and is fixed: NOP=0, ADD=1, SUB=2, AND=3, OR=4, SLT=5, SLTU=6, NOR=7, XOR=8, SLL=9, SRL=10, SRA=11, SLLV=12, SRLV=13, SRAV=14, SLL16=15.

Ports:

- `clk` input 1: the single clock; all state updates on its rising edge.
- `rst` input 1: reset, asynchronous, active-high.
- `id_valid` input 1: instruction word valid.
- `id_ready` output 1: the stage accepts this cycle.
- `id_instr` input 32: instruction word.
- `rf_raddr1` output 5: `id_instr[25:21]` (rs), combinational.
- `rf_raddr2` output 5: `id_instr[20:16]` (rt), combinational.
- `rf_rdata1` input 32: rs data, same cycle.
- `rf_rdata2` input 32: rt data, same cycle.
- `flush` input 1: discard the held and incoming instruction.
- `ex_valid` output 1: the ex_* outputs are valid.
- `ex_ready` input 1: the execute stage consumes this cycle.
- `ex_aluop` output 5: ALU operation code.
- `ex_a` output 32: ALU operand a.
- `ex_b` output 32: ALU operand b.
- `ex_wreg` output 5: destination register.
- `ex_wen` output 1: register write enable.
- `ex_trap_ovf` output 1: the ALU overflow must raise an exception (ADD/ADDI/SUB).
- `ex_illegal` output 1: unsupported instruction.

## Operation

- Handshake: `id_ready = !ex_valid || ex_ready`. A transfer occurs on `id_valid && id_ready`.
- R-type (op 0x00), dest = rd = `instr[15:11]`.
  - SLL/SRL/SRA, funct 0x00/0x02/0x03: aluop 9/10/11, a = {27'b0, shamt}, b = rt.
  - SLLV/SRLV/SRAV, funct 0x04/0x06/0x07: aluop 12/13/14, a = rs, b = rt.
  - ADD/ADDU, funct 0x20/0x21: aluop 1. SUB/SUBU, funct 0x22/0x23: aluop 2.
  - AND/OR/XOR/NOR, funct 0x24/0x25/0x26/0x27: aluop 3/4/8/7.
  - SLT/SLTU, funct 0x2A/0x2B: aluop 5/6.
  - For all non-shift R-type entries above: a = rs, b = rt.
- I-type, dest = rt, a = rs.
  - ADDI/ADDIU, op 0x08/0x09: aluop 1, b = sign-extended imm.
  - SLTI/SLTIU, op 0x0A/0x0B: aluop 5/6, b = sign-extended imm.
  - ANDI/ORI/XORI, op 0x0C/0x0D/0x0E: aluop 3/4/8, b = zero-extended imm.
  - LUI, op 0x0F: aluop 15, a = 0, b = zero-extended imm.
- `ex_trap_ovf` = 1 only for ADD, SUB and ADDI.
- `ex_wen` = 1 for every legal instruction whose dest ≠ 0. A dest of 0 forces `ex_wen` = 0; the all-zero word is therefore a true NOP.
- Any other opcode or funct is illegal:
  - ex_illegal=1, ex_aluop=0 (NOP), ex_a = rs, ex_b = 0.
  - ex_wen=0, ex_trap_ovf=0.
  - The word is still transferred as a valid slot.
- Register update, per cycle:
  - Transfer: load all ex_* fields, set ex_valid=1.
  - Else if `ex_ready`: clear ex_valid. Data fields hold their values.
  - Else: hold everything.
- flush has priority over everything. Next cycle ex_valid=0 and ex_wen=0. Any incoming word in the flush cycle is dropped; id_ready may be 1, but nothing is captured.

## Timing

- Reset (async, immediate): ex_valid=0, ex_aluop=0, ex_a=0, ex_b=0, ex_wreg=0, ex_wen=0, ex_trap_ovf=0, ex_illegal=0.
- Latency: one cycle, id_instr to ex_* outputs.
- Throughput: one instruction per cycle while ex_ready=1.
- Stall: with ex_valid=1 and ex_ready=0, all ex_* outputs are stable and id_ready=0.
- Simultaneous consume and accept (ex_valid=1, ex_ready=1, id_valid=1): the new word replaces the old one in the same edge with no bubble.
- Reset asserted mid-transfer: the register clears immediately. The first valid output comes one cycle after the first accepted word following deassertion.
- rf_raddr1/rf_raddr2 are purely combinational from id_instr and have no registered delay.

## Test plan

- ADDIU, id_instr=0x2509FFFF with rs data 0x00000010:
  - Next cycle: ex_aluop=1, ex_a=0x10, ex_b=0xFFFFFFFF, ex_wreg=9, ex_wen=1, ex_trap_ovf=0.
  - Also check rf_raddr1=8 in the same cycle.
- SLL, id_instr=0x00095100 with rt data 0xA5A5A5A5: ex_aluop=9, ex_a=4, ex_b=0xA5A5A5A5, ex_wreg=10, ex_wen=1.
- LUI, id_instr=0x3C0B1234: ex_aluop=15, ex_a=0, ex_b=0x00001234, ex_wreg=11. Then ADD 0x01095020: ex_aluop=1, ex_trap_ovf=1.
- Illegal opcode 0x23, id_instr=0x8D090000: ex_illegal=1, ex_aluop=0, ex_wen=0, ex_valid=1.
- Back-pressure:
  - Hold ex_ready=0 for 3 cycles with id_valid=1: outputs frozen, id_ready=0.
  - Release ex_ready: the next word appears one cycle later with no loss or duplication across a 4-word sequence.
- Flush and reset:
  - Assert flush while stalled: ex_valid=0 next cycle, and the stalled word never reappears.
  - Assert rst mid-stream: all outputs return to 0 asynchronously, before the next clock edge.
